// File: rtl/sd_pkg.sv
// Shared types and constants for the SD-card character buffer.
package sd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2
    } sd_state_e;

    localparam int SECTOR_BYTES_DEFAULT = 512;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_DOT   = 8'h2E;

    // Uppercase hex digit for a 4-bit value.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/sd_char_format.sv
// Combinational byte/nibble to ASCII mapper for the text renderer.
module sd_char_format
    import sd_pkg::*;
(
    input  logic [7:0] byte_in,
    input  logic       hex_mode,
    input  logic       nibble_lo,
    input  logic       frame_valid,
    output logic [7:0] char_out
);

    always_comb begin
        char_out = CHAR_SPACE;
        if (!frame_valid) begin
            char_out = CHAR_SPACE;
        end else if (hex_mode) begin
            char_out = nibble_to_ascii(nibble_lo ? byte_in[3:0] : byte_in[7:4]);
        end else if (byte_in >= 8'h20 && byte_in <= 8'h7E) begin
            char_out = byte_in;
        end else begin
            char_out = CHAR_DOT;
        end
    end

endmodule

// File: rtl/sd_char_buffer.sv
// Double-buffered 32-byte window captured from each SD sector, served as
// registered ASCII or hex characters from the front bank.
module sd_char_buffer
    import sd_pkg::*;
#(
    parameter int SECTOR_BYTES  = SECTOR_BYTES_DEFAULT,
    parameter int WINDOW_OFFSET = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sector_start,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       sector_done,
    input  logic       hex_mode,
    input  logic [4:0] char_addr,
    output logic [7:0] char_out,
    output logic       frame_valid,
    output logic       err_short
);

    // One extra bit so the counter can hold SECTOR_BYTES itself.
    localparam int CNT_W = $clog2(SECTOR_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SECTOR_BYTES);
    localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(WINDOW_OFFSET);

    sd_state_e        state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             bank_sel_q, bank_sel_d;
    logic             frame_valid_q, frame_valid_d;
    logic             err_short_q, err_short_d;
    logic [7:0]       char_out_q, char_out_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] win_off;
    logic             wr_en;
    logic [5:0]       wr_addr;

    logic [7:0]       bank_q [64];
    logic [4:0]       rd_idx;
    logic [7:0]       rd_byte;
    logic [7:0]       fmt_char;

    // Below the window the subtraction wraps far past 32, so one compare suffices.
    assign win_off = byte_cnt_q - WIN_LO;
    assign wr_addr = {~bank_sel_q, win_off[4:0]};

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        bank_sel_d    = bank_sel_q;
        frame_valid_d = frame_valid_q;
        err_short_d   = 1'b0;
        wr_en         = 1'b0;
        cnt_inc       = byte_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (sector_start) begin
                    byte_cnt_d = '0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (sector_start) begin
                    byte_cnt_d = '0;
                end else begin
                    if (byte_valid && byte_cnt_q != CNT_FULL) begin
                        cnt_inc = byte_cnt_q + CNT_W'(1);
                        wr_en   = (win_off < CNT_W'(32));
                    end
                    byte_cnt_d = cnt_inc;
                    if (sector_done) begin
                        if (cnt_inc == CNT_FULL) begin
                            state_d = ST_COMMIT;
                        end else begin
                            state_d     = ST_IDLE;
                            err_short_d = 1'b1;
                        end
                    end
                end
            end
            ST_COMMIT: begin
                bank_sel_d    = ~bank_sel_q;
                frame_valid_d = 1'b1;
                if (sector_start) begin
                    byte_cnt_d = '0;
                    state_d    = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bank storage is deliberately not reset; frame_valid masks stale data.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            bank_q[wr_addr] <= byte_data;
        end
    end

    assign rd_idx  = hex_mode ? {1'b0, char_addr[4:1]} : char_addr;
    assign rd_byte = bank_q[{bank_sel_q, rd_idx}];

    sd_char_format u_format (
        .byte_in     (rd_byte),
        .hex_mode    (hex_mode),
        .nibble_lo   (char_addr[0]),
        .frame_valid (frame_valid_q),
        .char_out    (fmt_char)
    );

    assign char_out_d = fmt_char;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            byte_cnt_q    <= '0;
            bank_sel_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            err_short_q   <= 1'b0;
            char_out_q    <= CHAR_SPACE;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            bank_sel_q    <= bank_sel_d;
            frame_valid_q <= frame_valid_d;
            err_short_q   <= err_short_d;
            char_out_q    <= char_out_d;
        end
    end

    assign char_out    = char_out_q;
    assign frame_valid = frame_valid_q;
    assign err_short   = err_short_q;

endmodule
